// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry
// valid/ready output register.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB  = clks_per_bit(CLK_HZ, BAUD_RATE);
    localparam int HALF = half_bit(CPB);
    localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    logic          rxs;
    logic          prev;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    out_data_n;
    logic          out_valid_n;
    logic          frame_err_n;
    logic          overrun_n;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            prev      <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            prev      <= rxs;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        idx_n       = idx;
        shreg_n     = shreg;
        out_data_n  = out_data;
        out_valid_n = out_valid && !out_ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                // Edge-triggered so a line stuck low cannot re-arm.
                if (prev && !rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_END) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rxs) begin
                        frame_err_n = 1'b1;
                    end else if (!out_valid || out_ready) begin
                        out_data_n  = shreg;
                        out_valid_n = 1'b1;
                    end else begin
                        overrun_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
